// File: rtl/regfile.sv
// Multi-port register file: one synchronous write port, two enable-gated
// combinational read ports. Asynchronous active-low reset clears all words.
module regfile #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] WA,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RAA,
  input  logic [ADDR_W-1:0] RBA,
  input  logic              RAE,
  input  logic              RBE,
  output logic [WIDTH-1:0]  portA,
  output logic [WIDTH-1:0]  portB
);

  logic [WIDTH-1:0] r [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r[i] <= '0;
      end
    end else if (WE) begin
      r[WA] <= D;
    end
  end

  // No write bypass: reads see the stored value until the write edge.
  always_comb begin
    portA = '0;
    portB = '0;
    if (RAE) portA = r[RAA];
    if (RBE) portB = r[RBA];
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  D;
  logic [ADDR_W-1:0] WA, RAA, RBA;
  logic              WE, RAE, RBE;
  logic [WIDTH-1:0]  portA, portB;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [WIDTH-1:0] model [DEPTH];

  regfile #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .D(D), .WA(WA), .WE(WE),
    .RAA(RAA), .RBA(RBA), .RAE(RAE), .RBE(RBE),
    .portA(portA), .portB(portB)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_read(input logic en, input logic [ADDR_W-1:0] a);
    return en ? model[a] : '0;
  endfunction

  // Inputs only change away from edges, so sampling them at the edge is safe.
  task automatic tick();
    @(posedge clk);
    if (rst_n && WE) model[WA] = D;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; WE = 1'b1; D = 8'hAA; WA = 2'd1;
    RAE = 1'b0; RBE = 1'b0; RAA = '0; RBA = '0;
    clear_model();
    tick(); tick();
    rst_n = 1'b1; WE = 1'b0;
    RAE = 1'b1; RBE = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      RAA = ADDR_W'(a); RBA = ADDR_W'(DEPTH - 1 - a);
      #1;
      n_checks++;
      if (portA !== 8'h00) begin
        n_fail++; $display("FAIL reset_portA addr=%0d got=%0h exp=00", a, portA);
      end
      n_checks++;
      if (portB !== 8'h00) begin
        n_fail++; $display("FAIL reset_portB addr=%0d got=%0h exp=00", DEPTH - 1 - a, portB);
      end
    end
  endtask

  task automatic test_basic();
    WE = 1'b1; WA = 2'd3; D = 8'd23; RAA = 2'd0; RBA = 2'd0;
    #1;
    n_checks++;
    if (portA !== 8'd0) begin n_fail++; $display("FAIL basic_pre_A got=%0d exp=0", portA); end
    n_checks++;
    if (portB !== 8'd0) begin n_fail++; $display("FAIL basic_pre_B got=%0d exp=0", portB); end
    tick();
    WE = 1'b0; RAA = 2'd3;
    #1;
    n_checks++;
    if (portA !== 8'd23) begin n_fail++; $display("FAIL basic_read_A got=%0d exp=23", portA); end
  endtask

  task automatic test_read_during_write();
    WE = 1'b1; WA = 2'd1; D = 8'd45; RBA = 2'd1; RBE = 1'b1;
    #1;
    n_checks++;
    if (portB !== 8'd0) begin n_fail++; $display("FAIL rdw_old_B got=%0d exp=0", portB); end
    tick();
    n_checks++;
    if (portB !== 8'd45) begin n_fail++; $display("FAIL rdw_new_B got=%0d exp=45", portB); end
    WE = 1'b0;
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] exp_tab [DEPTH];
    exp_tab[0] = 8'd89; exp_tab[1] = 8'd45; exp_tab[2] = 8'd67; exp_tab[3] = 8'd23;
    WE = 1'b1;
    WA = 2'd1; D = 8'd45; tick();
    WA = 2'd2; D = 8'd67; tick();
    WA = 2'd0; D = 8'd89; tick();
    WE = 1'b0; RAE = 1'b1; RBE = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      RAA = ADDR_W'(a); RBA = ADDR_W'(a);
      #1;
      n_checks++;
      if (portA !== exp_tab[a]) begin
        n_fail++; $display("FAIL fill_A addr=%0d got=%0d exp=%0d", a, portA, exp_tab[a]);
      end
      n_checks++;
      if (portB !== exp_tab[a]) begin
        n_fail++; $display("FAIL fill_B addr=%0d got=%0d exp=%0d", a, portB, exp_tab[a]);
      end
    end
  endtask

  task automatic test_enables();
    RAE = 1'b0; RAA = 2'd3; RBE = 1'b1; RBA = 2'd3;
    #1;
    n_checks++;
    if (portA !== 8'd0) begin n_fail++; $display("FAIL en_disabled_A got=%0d exp=0", portA); end
    n_checks++;
    if (portB !== 8'd23) begin n_fail++; $display("FAIL en_enabled_B got=%0d exp=23", portB); end
    RBE = 1'b0;
    #1;
    n_checks++;
    if (portB !== 8'd0) begin n_fail++; $display("FAIL en_disabled_B got=%0d exp=0", portB); end
    WE = 1'b0; WA = 2'd2; D = 8'hFF;
    tick(); tick(); tick();
    RAE = 1'b1; RAA = 2'd2;
    #1;
    n_checks++;
    if (portA !== 8'd67) begin n_fail++; $display("FAIL we_gate_R2 got=%0d exp=67", portA); end
  endtask

  task automatic test_async_reset();
    RAE = 1'b1; RBE = 1'b1; RAA = 2'd3; RBA = 2'd2; WE = 1'b1; WA = 2'd0; D = 8'h5A;
    @(negedge clk); #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    n_checks++;
    if (portA !== 8'd0) begin n_fail++; $display("FAIL async_rst_A got=%0d exp=0", portA); end
    n_checks++;
    if (portB !== 8'd0) begin n_fail++; $display("FAIL async_rst_B got=%0d exp=0", portB); end
    tick();
    rst_n = 1'b1; WE = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      RAA = ADDR_W'(a); RBA = ADDR_W'(a);
      #1;
      n_checks++;
      if (portA !== 8'd0 || portB !== 8'd0) begin
        n_fail++; $display("FAIL async_rst_sweep addr=%0d gotA=%0d gotB=%0d exp=0", a, portA, portB);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ea, eb;
    for (int n = 0; n < 300; n++) begin
      WE  = 1'($urandom_range(0, 1));
      WA  = ADDR_W'($urandom_range(0, DEPTH - 1));
      D   = WIDTH'($urandom);
      RAA = ADDR_W'($urandom_range(0, DEPTH - 1));
      RBA = ($urandom_range(0, 3) == 0) ? WA : ADDR_W'($urandom_range(0, DEPTH - 1));
      RAE = ($urandom_range(0, 4) != 0);
      RBE = ($urandom_range(0, 4) != 0);
      #1;
      ea = ref_read(RAE, RAA); eb = ref_read(RBE, RBA);
      n_checks++;
      if (portA !== ea) begin n_fail++; $display("FAIL rand_pre_A it=%0d got=%0h exp=%0h", n, portA, ea); end
      n_checks++;
      if (portB !== eb) begin n_fail++; $display("FAIL rand_pre_B it=%0d got=%0h exp=%0h", n, portB, eb); end
      tick();
      ea = ref_read(RAE, RAA); eb = ref_read(RBE, RBA);
      n_checks++;
      if (portA !== ea) begin n_fail++; $display("FAIL rand_post_A it=%0d got=%0h exp=%0h", n, portA, ea); end
      n_checks++;
      if (portB !== eb) begin n_fail++; $display("FAIL rand_post_B it=%0d got=%0h exp=%0h", n, portB, eb); end
    end
  endtask

  initial begin
    rst_n = 1'b0; D = '0; WA = '0; WE = 1'b0;
    RAA = '0; RBA = '0; RAE = 1'b0; RBE = 1'b0;
    clear_model();
    test_reset();
    test_basic();
    test_read_during_write();
    test_fill();
    test_enables();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
